// File: rtl/spwm_cmd_spi_pkg.sv
// Shared constants for the SPWM SPI command port: frame header, FSM encoding,
// register-bus addresses and the frame validity rule.
package spwm_cmd_spi_pkg;

  localparam logic [6:0]  HEADER_DEFAULT = 7'b1010000;
  localparam int unsigned FRAME_BITS     = 24;
  localparam logic [4:0]  BITCNT_SAT     = 5'd25;

  localparam logic ADDR_KW   = 1'b0;
  localparam logic ADDR_DUTY = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  function automatic logic frame_ok(input logic [23:0] frame,
                                    input logic [4:0]  nbits,
                                    input logic [6:0]  hdr);
    return (nbits == 5'(FRAME_BITS)) && (frame[23:17] == hdr);
  endfunction

endpackage

// File: rtl/spwm_cmd_spi_sync2.sv
// Two-flop synchronizer; IDLE sets the level both flops take during reset.
module sync2 #(
  parameter logic IDLE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= IDLE;
      q  <= IDLE;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/spwm_cmd_spi.sv
// SPI command slave: receives 24-bit {header, addr, data} frames, writes the
// KW / DutyCycle registers over a one-cycle bus strobe and reads them back on MISO.
module spwm_cmd_spi
  import spwm_cmd_spi_pkg::*;
#(
  parameter logic [6:0]  HEADER   = HEADER_DEFAULT,
  parameter logic [15:0] KW_RST   = 16'd141,
  parameter logic [9:0]  DUTY_RST = 10'd500
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        datacs,
  output logic        WR,
  output logic        dataAddr,
  output logic [15:0] wrdat,
  output logic [7:0]  err_cnt
);

  logic        sck_s, cs_s, mosi_s;
  logic        sck_q, cs_q, mosi_q;
  logic        sck_rise, sck_fall, cs_rise, cs_fall;
  logic [1:0]  settle;
  logic        armed;
  logic [1:0]  state;
  logic [23:0] shreg;
  logic [4:0]  bitcnt;
  logic        rd_addr;
  logic [15:0] kw;
  logic [9:0]  duty;
  logic [15:0] rd_word;
  logic [4:0]  miso_idx;

  sync2 #(.IDLE(1'b0)) u_sync_sck  (.clk(clk_50m), .rst(rst), .d(spi_sck),  .q(sck_s));
  sync2 #(.IDLE(1'b1)) u_sync_cs   (.clk(clk_50m), .rst(rst), .d(spi_cs_n), .q(cs_s));
  sync2 #(.IDLE(1'b0)) u_sync_mosi (.clk(clk_50m), .rst(rst), .d(spi_mosi), .q(mosi_s));

  // Edge pulses are registered; mosi_q keeps data aligned with sck_rise.
  // armed blocks the false cs_n fall seen when reset releases mid-frame.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_rise  <= 1'b0;
      cs_fall  <= 1'b0;
      settle   <= '0;
      armed    <= 1'b0;
    end else begin
      sck_q    <= sck_s;
      cs_q     <= cs_s;
      mosi_q   <= mosi_s;
      sck_rise <= sck_s & ~sck_q & ~cs_s;
      sck_fall <= ~sck_s & sck_q & ~cs_s;
      cs_rise  <= cs_s & ~cs_q;
      cs_fall  <= ~cs_s & cs_q & armed;
      if (settle != 2'd3) settle <= settle + 2'd1;
      armed    <= armed | ((settle == 2'd3) & cs_s);
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      rd_addr  <= ADDR_KW;
      datacs   <= 1'b0;
      WR       <= 1'b0;
      dataAddr <= ADDR_KW;
      wrdat    <= '0;
      err_cnt  <= '0;
      kw       <= KW_RST;
      duty     <= DUTY_RST;
    end else begin
      datacs <= 1'b0;
      WR     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_SHIFT;
            shreg   <= '0;
            bitcnt  <= '0;
            rd_addr <= ADDR_KW;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= ST_CHECK;
          end else if (sck_rise) begin
            shreg <= {shreg[22:0], mosi_q};
            if (bitcnt != BITCNT_SAT) bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd7) rd_addr <= mosi_q;
          end
        end
        ST_CHECK: begin
          if (frame_ok(shreg, bitcnt, HEADER)) begin
            state    <= ST_COMMIT;
            datacs   <= 1'b1;
            WR       <= 1'b1;
            dataAddr <= shreg[16];
            wrdat    <= shreg[15:0];
          end else begin
            state <= ST_IDLE;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          if (dataAddr == ADDR_KW) kw <= wrdat;
          else                     duty <= wrdat[9:0];
        end
      endcase
    end
  end

  assign rd_word  = (rd_addr == ADDR_DUTY) ? {6'b0, duty} : kw;
  assign miso_idx = 5'd23 - bitcnt;

  // bitcnt is the index of the next bit the master will sample.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      spi_miso <= 1'b0;
    end else if (cs_s || (state != ST_SHIFT)) begin
      spi_miso <= 1'b0;
    end else if (sck_fall) begin
      if ((bitcnt >= 5'd8) && (bitcnt <= 5'd23)) spi_miso <= rd_word[miso_idx[3:0]];
      else                                       spi_miso <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spwm_cmd_spi.sv
// Directed bench for spwm_cmd_spi: the bench acts as SPI master and watches the register bus.
module tb_spwm_cmd_spi;

  logic        clk_50m = 1'b0;
  logic        rst;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso, datacs, WR, dataAddr;
  logic [15:0] wrdat;
  logic [7:0]  err_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_pulses = 0;
  int          cs_wr_diff = 0;
  logic        last_addr;
  logic [15:0] last_data;
  logic [15:0] rd_acc;
  int          lat;

  spwm_cmd_spi #(.HEADER(7'b1010000), .KW_RST(16'd141), .DUTY_RST(10'd500)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .spi_sck (spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .datacs  (datacs),
    .WR      (WR),
    .dataAddr(dataAddr),
    .wrdat   (wrdat),
    .err_cnt (err_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    if (WR === 1'b1) begin
      wr_pulses++;
      last_addr = dataAddr;
      last_data = wrdat;
    end
    if (WR !== datacs) cs_wr_diff++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_50m) rst = 1'b1;
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;
    repeat (10) @(negedge clk_50m);
  endtask

  // Mode 0 master: drive MOSI, sample MISO just before the rising edge.
  task automatic spi_bits(input logic [31:0] frame, input int unsigned nbits,
                          input int unsigned from, input int unsigned upto);
    for (int unsigned i = from; i < upto; i++) begin
      spi_mosi = frame[nbits-1-i];
      #200;
      if (i >= 8 && i <= 23) rd_acc = {rd_acc[14:0], spi_miso};
      spi_sck = 1'b1;
      #200;
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] frame, input int unsigned nbits);
    rd_acc   = '0;
    spi_cs_n = 1'b0;
    #400;
    spi_bits(frame, nbits, 0, nbits);
  endtask

  // Raises cs_n and returns the clk count from the first edge seeing it high to WR (-1 if none).
  task automatic end_frame(output int latency);
    #200;
    @(negedge clk_50m) spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    @(posedge clk_50m);
    latency = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_50m);
      #1;
      if (WR === 1'b1 && latency < 0) latency = k;
    end
    #600;
  endtask

  task automatic empty_frame();
    spi_cs_n = 1'b0;
    #200;
    spi_cs_n = 1'b1;
    #300;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    #55;
    check("rst_wr",     {31'b0, WR},       32'd0);
    check("rst_datacs", {31'b0, datacs},   32'd0);
    check("rst_miso",   {31'b0, spi_miso}, 32'd0);
    check("rst_addr",   {31'b0, dataAddr}, 32'd0);
    check("rst_wrdat",  {16'b0, wrdat},    32'd0);
    check("rst_err",    {24'b0, err_cnt},  32'd0);
    @(negedge clk_50m) rst = 1'b0;
    repeat (10) @(negedge clk_50m);

    // KW write 0x8D00; readback shows KW reset value 141
    spi_frame(32'hA08D00, 24);
    check("kw_rd_reset", {16'b0, rd_acc}, 32'h008D);
    end_frame(lat);
    check("kw_latency",  lat, 32'd4);
    check("kw_pulses",   wr_pulses, 32'd1);
    check("kw_addr",     {31'b0, last_addr}, 32'd0);
    check("kw_data",     {16'b0, last_data}, 32'h8D00);
    check("kw_err",      {24'b0, err_cnt}, 32'd0);
    check("kw_hold",     {15'b0, dataAddr, wrdat}, 32'h0_8D00);
    check("kw_wr_low",   {31'b0, WR}, 32'd0);

    do_reset();
    spi_frame(32'hA101F4, 24);
    check("duty_rd1", {16'b0, rd_acc}, 32'h01F4);
    end_frame(lat);
    check("duty_lat1", lat, 32'd4);
    spi_frame(32'hA101F4, 24);
    check("duty_rd2", {16'b0, rd_acc}, 32'h01F4);
    end_frame(lat);
    spi_frame(32'hA1FC20, 24);
    check("duty_rd3", {16'b0, rd_acc}, 32'h01F4);
    end_frame(lat);
    check("duty_hi_commit", lat, 32'd4);
    check("duty_bus", {15'b0, dataAddr, wrdat}, 32'h1_FC20);
    spi_frame(32'hA10020, 24);
    check("duty_rd4", {16'b0, rd_acc}, 32'h0020);
    end_frame(lat);
    check("duty_pulses", wr_pulses, 32'd5);

    spi_frame(32'hA08D, 16);
    end_frame(lat);
    check("short_nowr", lat, 32'hFFFF_FFFF);
    spi_frame(32'h1411A00, 25);
    end_frame(lat);
    check("long_nowr", lat, 32'hFFFF_FFFF);
    spi_frame(32'hA21234, 24);
    end_frame(lat);
    check("hdr_nowr",   lat, 32'hFFFF_FFFF);
    check("bad_err3",   {24'b0, err_cnt}, 32'd3);
    check("bad_pulses", wr_pulses, 32'd5);
    check("bad_hold",   {15'b0, dataAddr, wrdat}, 32'h1_0020);

    for (int i = 0; i < 252; i++) empty_frame();
    check("err_sat", {24'b0, err_cnt}, 32'd255);
    for (int i = 0; i < 8; i++) empty_frame();
    check("err_nowrap", {24'b0, err_cnt}, 32'd255);

    // Reset lands at bit 20 of a valid frame; the rest of the frame must be discarded
    rd_acc   = '0;
    spi_cs_n = 1'b0;
    #400;
    spi_bits(32'hA0ABCD, 24, 0, 20);
    rst = 1'b1;
    #100;
    check("mid_rst_wr", {31'b0, WR}, 32'd0);
    rst = 1'b0;
    spi_bits(32'hA0ABCD, 24, 20, 24);
    end_frame(lat);
    check("mid_nowr",   lat, 32'hFFFF_FFFF);
    check("mid_err",    {24'b0, err_cnt}, 32'd0);
    check("mid_bus",    {15'b0, dataAddr, wrdat}, 32'd0);
    check("mid_miso",   {30'b0, spi_miso, datacs}, 32'd0);
    spi_frame(32'hA0008D, 24);
    check("mid_kw_rd",  {16'b0, rd_acc}, 32'd141);
    end_frame(lat);
    check("mid_kw_lat", lat, 32'd4);
    check("mid_pulses", wr_pulses, 32'd6);
    check("cs_eq_wr",   cs_wr_diff, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
